uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Round-robin scheduler that shares the single UART transmit path between `NUM_REQ` byte producers. It captures one byte from the winning requester, starts the transmitter with a one-cycle `tx_start`, and tracks the transmitter through busy and done. It then enforces an inter-frame gap before the next grant. It sits between the producers and the transmitter's `enable_trans`/`data_in`/`trans_flag`/`tx_done` handshake.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `GAP_CYCLES`, 2: idle clocks after `tx_done` before the next grant; 0 is legal.
- `START_TIMEOUT`, 16: clocks to wait for `tx_busy` after `tx_start` before flagging an error; ≥1.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset (asserts when 0).
- `req` in `NUM_REQ`: per-requester level request; held with `req_data` until `req_ack`.
- `req_data` in `NUM_REQ*8`: byte of requester i at bits [8i+7:8i].
- `req_ack` out `NUM_REQ`: one-hot, one-cycle pulse; byte of that requester captured.
- `tx_start` out 1: one-cycle start pulse to the transmitter (drives `enable_trans`).
- `tx_data` out 8: captured byte; stable from the `req_ack` cycle until the next capture.
- `tx_busy` in 1: transmitter flag (`trans_flag`).
- `tx_done` in 1: transmitter frame-complete pulse.
- `grant_id` out `$clog2(NUM_REQ)`: index of the last granted requester.
- `busy` out 1: high in every state except IDLE.
- `err_timeout` out 1: sticky; set on start timeout.
- `err_clr` in 1: clears `err_timeout`; a set in the same cycle wins.

## Operation
- States:
  - IDLE: if any `req` is high, pick the winner, capture `req_data[winner]` into `tx_data`, pulse `req_ack[winner]`, load `grant_id`, advance the pointer, go to START. Otherwise stay.
  - START: `tx_start`=1 for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY:
    - `tx_done`=1 → GAP; `tx_done` has priority over `tx_busy` in the same cycle.
    - else `tx_busy`=1 → WAIT_DONE.
    - else count; at count = `START_TIMEOUT`-1, set `err_timeout` and go to IDLE. The byte is dropped, not retried.
  - WAIT_DONE: `tx_done`=1 → GAP, else stay. There is no timeout here.
  - GAP: load the counter with `GAP_CYCLES` on entry; decrement each cycle; go to IDLE when it reaches 0. If `GAP_CYCLES`=0, WAIT_* goes directly to IDLE.
- Arbitration: round-robin pointer `rr_ptr` (`$clog2(NUM_REQ)` bits).
  - Search order is `rr_ptr`, `rr_ptr`+1, … modulo `NUM_REQ`; the first high `req` wins.
  - After a grant to i, `rr_ptr` = (i+1) mod `NUM_REQ`; it wraps from `NUM_REQ`-1 to 0.
  - The pointer does not move without a grant.
- `req` changes outside IDLE are ignored. A requester may drop `req` before its ack; it is then simply not granted.
- `tx_busy`/`tx_done` in IDLE or GAP are ignored.
- Reset values: state=IDLE, `rr_ptr`=0, and every output 0 (`req_ack`, `tx_start`, `tx_data`, `grant_id`, `busy`, `err_timeout`).
- Reset mid-frame: immediate return to IDLE with no ack or start pulse. The transmitter's own reset handles the frame in flight.

## Timing
- `req` high in IDLE at edge N → `req_ack` and `tx_data` valid after edge N; `tx_start` after edge N+1. Request-to-start latency is 2 clocks.
- `req_ack` and `tx_start` are never high in the same cycle.
- `tx_done` at edge M → next `req_ack` no earlier than edge M+`GAP_CYCLES`+1.
- Minimum grant-to-grant spacing is 4+`GAP_CYCLES` clocks, assuming one-cycle busy and done responses.
- Timeout: no `tx_busy`/`tx_done` for `START_TIMEOUT` clocks after START → `err_timeout` high on the next edge, state IDLE.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `uart_pkg`: state encoding constants (IDLE, START, WAIT_BUSY, WAIT_DONE, GAP) and the byte width constant 8, shared with the transmitter and receiver blocks.
- One sub-module: `rr_arbiter`, purely combinational. Inputs are `req` and `rr_ptr`; outputs are a one-hot winner, the winner index, and `any_req`. The FSM, counters, and registers stay in `uart_tx_scheduler`.

## Test plan
- Single request: `req`=0001, byte 0xA5; `tx_busy` one cycle after start, `tx_done` 10 cycles later → `req_ack`=0001 and `tx_data`=0xA5 at +1, one `tx_start` at +2, `grant_id`=0, next grant only after the gap.
- Fairness: all four `req` held high, bytes 0x10..0x13 → grants in order 0,1,2,3,0, each `req_ack` a single pulse, `rr_ptr` wraps 3→0.
- Skip and wrap: `rr_ptr`=2, `req`=0011 → requester 0 wins, pointer becomes 1; the next grant with `req`=0011 goes to 1.
- Timeout: `tx_busy` and `tx_done` held 0 → `err_timeout` set after 16 clocks, state IDLE. `err_clr` clears it; `err_clr` asserted in the same cycle as a new timeout leaves the flag set.
- Corner events: `tx_done` and `tx_busy` high together in WAIT_BUSY → GAP. With `GAP_CYCLES`=0, the next grant comes on the cycle after done.
- Reset: `reset`=0 during WAIT_DONE → all outputs 0 asynchronously, `busy`=0. After release, a pending `req`=0100 is granted with `rr_ptr` starting from 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the transmit scheduler state encoding.
package uart_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_GAP       = 3'd4
   } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first high request at or after rr_ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] winner_oh,
   output logic [PTR_W-1:0]   winner_idx,
   output logic               any_req
);

   logic [PTR_W-1:0] sel;

   always_comb begin
      winner_oh  = '0;
      winner_idx = '0;
      any_req    = 1'b0;
      sel        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sel = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!any_req && req[sel]) begin
            any_req        = 1'b1;
            winner_oh[sel] = 1'b1;
            winner_idx     = sel;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ byte producers with round-robin grants,
// start-timeout detection and an enforced inter-frame gap.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for any request; grant, capture byte, ack
// START     | raise tx_start for one cycle, arm start timeout
// WAIT_BUSY | wait for transmitter busy or done; timeout drops the byte
// WAIT_DONE | transmitter busy, wait for frame complete
// GAP       | inter-frame idle time before the next grant
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int GAP_CYCLES    = 2,
   parameter int START_TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*BYTE_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         req_ack,
   output logic                       tx_start,
   output logic [BYTE_W-1:0]          tx_data,
   input  logic                       tx_busy,
   input  logic                       tx_done,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       err_timeout,
   input  logic                       err_clr
);

   localparam int PTR_W   = $clog2(NUM_REQ);
   localparam int CNT_MAX = (GAP_CYCLES > START_TIMEOUT - 1) ? GAP_CYCLES : START_TIMEOUT - 1;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

   sched_state_t        state, state_nx;
   logic [CNT_W-1:0]    cnt, cnt_nx;
   logic [PTR_W-1:0]    rr_ptr, ptr_nx;
   logic [NUM_REQ-1:0]  ack_nx;
   logic                start_nx, busy_nx, err_nx, timeout_hit;
   logic [BYTE_W-1:0]   data_nx, win_byte;
   logic [PTR_W-1:0]    gid_nx;

   logic [NUM_REQ-1:0]  win_oh;
   logic [PTR_W-1:0]    win_idx;
   logic                any_req;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .req        (req),
      .rr_ptr     (rr_ptr),
      .winner_oh  (win_oh),
      .winner_idx (win_idx),
      .any_req    (any_req)
   );

   always_comb begin
      win_byte = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == PTR_W'(i)) win_byte = req_data[i*BYTE_W +: BYTE_W];
      end
   end

   // One shared down-counter: start timeout in WAIT_BUSY, gap length in GAP.
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      ptr_nx      = rr_ptr;
      ack_nx      = '0;
      start_nx    = 1'b0;
      data_nx     = tx_data;
      gid_nx      = grant_id;
      timeout_hit = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any_req) begin
               ack_nx   = win_oh;
               data_nx  = win_byte;
               gid_nx   = win_idx;
               ptr_nx   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
               state_nx = ST_START;
            end
         end
         ST_START: begin
            start_nx = 1'b1;
            cnt_nx   = CNT_W'(START_TIMEOUT - 1);
            state_nx = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_done) begin
               cnt_nx   = CNT_W'(GAP_CYCLES);
               state_nx = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end else if (tx_busy) begin
               state_nx = ST_WAIT_DONE;
            end else if (cnt == '0) begin
               timeout_hit = 1'b1;
               state_nx    = ST_IDLE;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (tx_done) begin
               cnt_nx   = CNT_W'(GAP_CYCLES);
               state_nx = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
         end
         ST_GAP: begin
            cnt_nx = (cnt == '0) ? '0 : cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
      err_nx  = timeout_hit ? 1'b1 : (err_clr ? 1'b0 : err_timeout);
      busy_nx = (state_nx != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         rr_ptr      <= '0;
         req_ack     <= '0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         grant_id    <= '0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         rr_ptr      <= ptr_nx;
         req_ack     <= ack_nx;
         tx_start    <= start_nx;
         tx_data     <= data_nx;
         grant_id    <= gid_nx;
         busy        <= busy_nx;
         err_timeout <= err_nx;
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed literal scenarios plus randomized traffic
// checked every cycle against a timestamp-based behavioural model.
module tb_uart_tx_scheduler;

   localparam int NREQ = 4;
   localparam int GAP  = 2;
   localparam int TMO  = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ack;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy = 1'b0;
   logic        tx_done = 1'b0;
   logic [1:0]  grant_id;
   logic        busy;
   logic        err_timeout;
   logic        err_clr = 1'b0;

   logic [3:0]  req0 = '0;
   logic [31:0] req_data0 = '0;
   logic [3:0]  req_ack0;
   logic        tx_start0;
   logic [7:0]  tx_data0;
   logic        tx_busy0 = 1'b0;
   logic        tx_done0 = 1'b0;
   logic [1:0]  grant_id0;
   logic        busy0;
   logic        err0;
   logic        err_clr0 = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_scheduler #(.NUM_REQ(NREQ), .GAP_CYCLES(GAP), .START_TIMEOUT(TMO)) u_dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_ack(req_ack),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
      .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
   );

   uart_tx_scheduler #(.NUM_REQ(NREQ), .GAP_CYCLES(0), .START_TIMEOUT(TMO)) u_dut_gap0 (
      .clk(clk), .reset(reset), .req(req0), .req_data(req_data0), .req_ack(req_ack0),
      .tx_start(tx_start0), .tx_data(tx_data0), .tx_busy(tx_busy0), .tx_done(tx_done0),
      .grant_id(grant_id0), .busy(busy0), .err_timeout(err0), .err_clr(err_clr0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: a frame is tracked by the cycle of its grant, whether busy
   // was seen, and the cycle of done; outputs follow from those timestamps.
   logic [3:0] m_ack = '0;
   logic       m_start = 1'b0;
   logic [7:0] m_data = '0;
   logic [1:0] m_gid = '0;
   logic       m_busy = 1'b0;
   logic       m_err = 1'b0;
   int         m_ptr = 0, m_cyc = 0, m_grant = -100, m_done = -1, m_w = -1;
   bit         m_seen = 1'b0, m_hit = 1'b0;

   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         m_ack = '0; m_start = 1'b0; m_data = '0; m_gid = '0; m_busy = 1'b0; m_err = 1'b0;
         m_ptr = 0; m_grant = -100; m_done = -1; m_seen = 1'b0;
      end else begin
         m_cyc++;
         m_hit   = 1'b0;
         m_start = m_busy && (m_cyc == m_grant + 1);
         m_ack   = '0;
         if (!m_busy) begin
            if (req != 4'b0) begin
               m_w = -1;
               for (int k = 0; k < NREQ; k++)
                  if (m_w < 0 && req[2'((m_ptr + k) % NREQ)]) m_w = (m_ptr + k) % NREQ;
               m_ack   = 4'(1 << m_w);
               m_data  = 8'(req_data >> (8 * m_w));
               m_gid   = 2'(m_w);
               m_ptr   = (m_w + 1) % NREQ;
               m_busy  = 1'b1;
               m_grant = m_cyc;
               m_seen  = 1'b0;
               m_done  = -1;
            end
         end else if (m_cyc >= m_grant + 2) begin
            if (m_done < 0) begin
               if (tx_done) begin
                  m_done = m_cyc;
                  if (GAP == 0) m_busy = 1'b0;
               end else if (!m_seen) begin
                  if (tx_busy) m_seen = 1'b1;
                  else if (m_cyc - m_grant - 1 >= TMO) begin
                     m_hit  = 1'b1;
                     m_busy = 1'b0;
                  end
               end
            end else if (m_cyc >= m_done + GAP) begin
               m_busy = 1'b0;
            end
         end
         if (m_hit) m_err = 1'b1;
         else if (err_clr) m_err = 1'b0;
      end
   end

   initial forever begin
      @(negedge clk);
      chk("req_ack", 32'(req_ack), 32'(m_ack));
      chk("tx_start", 32'(tx_start), 32'(m_start));
      chk("tx_data", 32'(tx_data), 32'(m_data));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("err_timeout", 32'(err_timeout), 32'(m_err));
   end

   // Transmitter emulation for the main instance
   bit auto_tx = 1'b0, noise = 1'b0;
   int force_mode = -1, xt = -1, xm = 0, bl = 0, dl = 1;

   task automatic tx_emu();
      int r;
      if (tx_start) begin
         xt = 0;
         if (force_mode >= 0) begin
            xm = force_mode; bl = 0; dl = 3;
         end else begin
            r  = $urandom_range(0, 9);
            xm = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            bl = $urandom_range(0, 3);
            dl = $urandom_range(1, 10);
         end
      end else if (xt >= 0) begin
         xt++;
      end
      if (xt > 40) xt = -1;
      tx_busy = 1'b0;
      tx_done = 1'b0;
      if (xt < 0) begin
         if (noise) begin
            tx_busy = ($urandom_range(0, 4) == 0);
            tx_done = ($urandom_range(0, 4) == 0);
         end
      end else if (xm == 2) begin
         if (xt == bl) begin tx_busy = 1'b1; tx_done = 1'b1; xt = -1; end
      end else if (xm == 0) begin
         tx_busy = (xt >= bl) && (xt < bl + dl);
         if (xt == bl + dl) begin tx_done = 1'b1; xt = -1; end
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (auto_tx) tx_emu();
   endtask

   task automatic wait_ack(output int id, output bit ok);
      ok = 1'b0;
      id = -1;
      for (int i = 0; i < 60; i++) begin
         step();
         if (req_ack != 4'b0) begin
            ok = 1'b1;
            id = int'(grant_id);
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL wait_ack: no req_ack within 60 cycles @%0t", $time);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int id;
      bit ok;
      repeat (3) step();
      chk("rst_ack", 32'(req_ack), 32'h0);
      chk("rst_start", 32'(tx_start), 32'h0);
      chk("rst_data", 32'(tx_data), 32'h0);
      chk("rst_gid", 32'(grant_id), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_err", 32'(err_timeout), 32'h0);
      reset = 1'b1;
      step();

      // GAP_CYCLES = 0: regrant on the cycle after done
      req0 = 4'b0001; req_data0 = 32'h3C;
      step(); chk("g0_ack", 32'(req_ack0), 32'h1); chk("g0_data", 32'(tx_data0), 32'h3C);
      step(); chk("g0_start", 32'(tx_start0), 32'h1); tx_busy0 = 1'b1;
      step(); tx_busy0 = 1'b0; tx_done0 = 1'b1;
      step(); tx_done0 = 1'b0; chk("g0_idle", 32'(busy0), 32'h0);
      step(); chk("g0_regrant", 32'(req_ack0), 32'h1); req0 = 4'b0;

      // Single request with 0xA5, then gap, then a timed-out frame
      req = 4'b0001; req_data = 32'hA5;
      step();
      chk("single_ack", 32'(req_ack), 32'h1);
      chk("single_data", 32'(tx_data), 32'hA5);
      chk("single_gid", 32'(grant_id), 32'h0);
      chk("single_nostart", 32'(tx_start), 32'h0);
      req = 4'b0;
      step();
      chk("single_start", 32'(tx_start), 32'h1);
      chk("single_ack_once", 32'(req_ack), 32'h0);
      tx_busy = 1'b1;
      repeat (10) step();
      tx_done = 1'b1; req = 4'b0001; req_data = 32'h5A;
      step(); tx_done = 1'b0; tx_busy = 1'b0;
      step(); chk("gap_noack1", 32'(req_ack), 32'h0); chk("gap_busy", 32'(busy), 32'h1);
      step(); chk("gap_noack2", 32'(req_ack), 32'h0); chk("gap_idle", 32'(busy), 32'h0);
      step(); chk("gap_regrant", 32'(req_ack), 32'h1); chk("gap_data", 32'(tx_data), 32'h5A);
      req = 4'b0;
      repeat (16) step();
      chk("tmo_not_yet", 32'(err_timeout), 32'h0);
      chk("tmo_busy", 32'(busy), 32'h1);
      step();
      chk("tmo_set", 32'(err_timeout), 32'h1);
      chk("tmo_idle", 32'(busy), 32'h0);
      err_clr = 1'b1;
      step(); chk("tmo_clr", 32'(err_timeout), 32'h0); err_clr = 1'b0;
      req = 4'b0010;
      step(); chk("tmo2_gid", 32'(grant_id), 32'h1); req = 4'b0;
      repeat (16) step();
      err_clr = 1'b1;
      step(); chk("tmo_set_wins", 32'(err_timeout), 32'h1); err_clr = 1'b0;
      err_clr = 1'b1;
      step(); chk("tmo_clr2", 32'(err_timeout), 32'h0); err_clr = 1'b0;

      // Reset during WAIT_DONE, then pointer restarts from 0
      req = 4'b1100; req_data = 32'h33220000;
      step(); chk("pre_rst_gid", 32'(grant_id), 32'h2); req = 4'b0;
      step(); tx_busy = 1'b1;
      step();
      step();
      #2 reset = 1'b0;
      #1;
      chk("arst_ack", 32'(req_ack), 32'h0);
      chk("arst_start", 32'(tx_start), 32'h0);
      chk("arst_data", 32'(tx_data), 32'h0);
      chk("arst_gid", 32'(grant_id), 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_err", 32'(err_timeout), 32'h0);
      tx_busy = 1'b0; req = 4'b1100;
      step(); reset = 1'b1;
      step();
      chk("post_rst_ack", 32'(req_ack), 32'h4);
      chk("post_rst_gid", 32'(grant_id), 32'h2);
      chk("post_rst_data", 32'(tx_data), 32'h22);
      req = 4'b0;
      repeat (20) step();
      err_clr = 1'b1; step(); err_clr = 1'b0;

      // Fairness from a fresh pointer
      #2 reset = 1'b0;
      step(); reset = 1'b1;
      auto_tx = 1'b1; force_mode = 0; noise = 1'b0;
      req = 4'b1111; req_data = 32'h13121110;
      for (int k = 0; k < 5; k++) begin
         wait_ack(id, ok);
         if (ok) begin
            chk("fair_order", 32'(id), 32'(k % 4));
            chk("fair_data", 32'(tx_data), 32'(8'h10 + 8'(k % 4)));
         end
      end
      req = 4'b0010;
      wait_ack(id, ok);
      if (ok) chk("skip_pre", 32'(id), 32'h1);
      req = 4'b0011;
      wait_ack(id, ok);
      if (ok) chk("skip_wrap0", 32'(id), 32'h0);
      wait_ack(id, ok);
      if (ok) chk("skip_next1", 32'(id), 32'h1);
      req = 4'b0;

      // busy and done together in WAIT_BUSY
      force_mode = 2;
      req = 4'b0001;
      wait_ack(id, ok);
      req = 4'b0;
      repeat (3) step();
      chk("both_gap", 32'(busy), 32'h1);
      step();
      chk("both_idle", 32'(busy), 32'h0);

      // Randomized traffic
      force_mode = -1; noise = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         step();
         for (int i = 0; i < NREQ; i++) begin
            if (req[i] && req_ack[i]) req[i] = 1'b0;
            else if (!req[i] && $urandom_range(0, 7) == 0) begin
               req[i] = 1'b1;
               req_data[i*8 +: 8] = 8'($urandom);
            end else if (req[i] && $urandom_range(0, 63) == 0) req[i] = 1'b0;
         end
         err_clr = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 599) == 0) begin
            #2 reset = 1'b0;
            step();
            reset = 1'b1;
         end
      end
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
